// File: rtl/store_pkg.sv
// Shared encodings for the store narrowing path: access sizes, packer states
// and the number of byte lanes in a data word.
package store_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        EMPTY,
        COLLECT,
        DRAIN
    } state_e;

endpackage

// File: rtl/store_lane_align.sv
// Places a byte/half/word store onto little-endian byte lanes of a 32-bit word
// and produces the matching byte enables; purely combinational.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       addr,
    input  logic [31:0]      data,
    output logic [31:0]      lane_data,
    output logic [LANES-1:0] be,
    output logic             misaligned
);

    assign misaligned = (size == SZ_RSVD)
                     || ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr != 2'b00));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic       hit;
            logic [7:0] src;

            // Each lane picks the source byte it would carry for each size.
            always_comb begin
                hit = 1'b0;
                src = data[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        hit = (addr == 2'(gi));
                        src = data[7:0];
                    end
                    SZ_HALF: begin
                        hit = (addr[1] == 1'(gi / 2));
                        src = data[8*(gi % 2) +: 8];
                    end
                    SZ_WORD: hit = 1'b1;
                    default: hit = 1'b0;
                endcase
            end

            assign be[gi]                = hit && !misaligned;
            assign lane_data[8*gi +: 8]  = be[gi] ? src : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/store_narrow_packer.sv
// Collects narrow stores to one aligned word in a single-entry buffer and
// issues a single word-aligned, byte-enabled write to the data memory port.
module store_narrow_packer
    import store_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int IDLE_FLUSH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic [31:0]       in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic [3:0]        out_be,
    output logic              misalign_err
);

    localparam int CNT_W = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH + 1) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_FLUSH);

    state_e              state_reg, state_next;
    logic [ADDR_W-3:0]   word_reg, word_next;
    logic [31:0]         data_reg, data_next;
    logic [LANES-1:0]    be_reg, be_next;
    logic [CNT_W-1:0]    idle_reg, idle_next;
    logic                misalign_err_reg;

    logic [31:0]         lane_data;
    logic [LANES-1:0]    new_be;
    logic                misaligned;
    logic                same_word;
    logic                accept;
    logic                aligned_accept;
    logic                waiting;
    logic                timeout;
    logic [LANES-1:0]    take_be;
    logic [LANES-1:0]    merged_be;
    logic [31:0]         merged_data;

    store_lane_align u_align (
        .size       (in_size),
        .addr       (in_addr[1:0]),
        .data       (in_data),
        .lane_data  (lane_data),
        .be         (new_be),
        .misaligned (misaligned)
    );

    assign same_word = (in_addr[ADDR_W-1:2] == word_reg);

    // A request for another word is held off until the current buffer drains.
    assign in_ready = (state_reg == EMPTY)
                   || ((state_reg == COLLECT) && !(in_valid && !same_word));

    assign accept         = in_valid && in_ready;
    assign aligned_accept = accept && !misaligned;
    assign waiting        = in_valid && !in_ready;
    assign timeout        = (IDLE_FLUSH > 0) && (idle_reg == IDLE_LAST) && !aligned_accept;
    assign take_be        = aligned_accept ? new_be : '0;
    assign merged_be      = be_reg | take_be;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_merge
            assign merged_data[8*gi +: 8] = take_be[gi] ? lane_data[8*gi +: 8]
                                                        : data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        data_next  = data_reg;
        be_next    = be_reg;
        idle_next  = idle_reg;
        case (state_reg)
            EMPTY: begin
                idle_next = '0;
                if (aligned_accept) begin
                    word_next  = in_addr[ADDR_W-1:2];
                    data_next  = lane_data;
                    be_next    = new_be;
                    state_next = ((&new_be) || flush) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (aligned_accept) begin
                    data_next = merged_data;
                    be_next   = merged_be;
                    idle_next = '0;
                end else if ((IDLE_FLUSH > 0) && (idle_reg != IDLE_MAX)) begin
                    idle_next = idle_reg + 1'b1;
                end
                if ((&merged_be) || flush || waiting || timeout) begin
                    state_next = DRAIN;
                    idle_next  = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    data_next  = '0;
                    be_next    = '0;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= EMPTY;
            word_reg         <= '0;
            data_reg         <= '0;
            be_reg           <= '0;
            idle_reg         <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            word_reg         <= word_next;
            data_reg         <= data_next;
            be_reg           <= be_next;
            idle_reg         <= idle_next;
            misalign_err_reg <= accept && misaligned;
        end
    end

    assign out_valid    = (state_reg == DRAIN);
    assign out_addr     = {word_reg, 2'b00};
    assign out_data     = data_reg;
    assign out_be       = be_reg;
    assign misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_store_narrow_packer.sv
// Randomized and directed bench for store_narrow_packer, scored against a
// byte-array model of the word buffer built from the store rules.
module tb_store_narrow_packer;

    localparam int ADDR_W = 32;
    localparam int IDLE   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic [31:0]       in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;
    logic [3:0]        out_be;
    logic              misalign_err;

    always #5 clk = ~clk;

    store_narrow_packer #(.ADDR_W(ADDR_W), .IDLE_FLUSH(IDLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_size      (in_size),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_be       (out_be),
        .misalign_err (misalign_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference buffer: which word, which bytes, whether it is being written out.
    bit          m_has;
    bit          m_drain;
    logic [29:0] m_word;
    logic [7:0]  m_bytes [4];
    logic [3:0]  m_mask;
    int          m_idle;
    bit          m_err;
    int          m_wr_cnt;

    int          dut_wr_cnt;
    int          dut_err_cnt;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(input logic [31:0] a, input bit v);
        return !m_drain && !(m_has && v && (a[31:2] != m_word));
    endfunction

    task automatic model_clear();
        m_has   = 0;
        m_drain = 0;
        m_word  = '0;
        m_mask  = '0;
        m_idle  = 0;
        m_err   = 0;
        for (int k = 0; k < 4; k++) m_bytes[k] = 8'h00;
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic cycle();
        bit          rdy, acc, mis, aligned, was_has, waiting;
        int          nb, lane, lo, idle_before;
        logic [31:0] exp_data;
        @(negedge clk);
        if (out_valid && out_ready && !reset) begin
            dut_wr_cnt++;
            last_addr = out_addr;
            last_data = out_data;
            last_be   = out_be;
            $display("write addr=0x%08h data=0x%08h be=%b", out_addr, out_data, out_be);
        end
        if (misalign_err && !reset) dut_err_cnt++;
        if (reset) begin
            model_clear();
        end else begin
            rdy = model_ready(in_addr, in_valid);
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("out_valid", 32'(out_valid), 32'(m_drain));
            check("misalign_err", 32'(misalign_err), 32'(m_err));
            if (m_drain) begin
                for (int k = 0; k < 4; k++) exp_data[8*k +: 8] = m_bytes[k];
                check("out_addr", out_addr, {m_word, 2'b00});
                check("out_data", out_data, exp_data);
                check("out_be", 32'(out_be), 32'(m_mask));
            end
            m_err = 0;
            if (m_drain) begin
                if (out_ready) begin
                    m_wr_cnt++;
                    m_drain = 0;
                    m_has   = 0;
                    m_mask  = '0;
                end
            end else begin
                acc = in_valid && rdy;
                lo  = int'(in_addr[1:0]);
                if (in_size == 2'd3) begin
                    nb  = 0;
                    mis = 1;
                end else begin
                    nb  = 1 << in_size;
                    mis = (lo % nb) != 0;
                end
                aligned     = acc && !mis;
                m_err       = acc && mis;
                was_has     = m_has;
                waiting     = in_valid && !rdy;
                idle_before = m_idle;
                if (aligned) begin
                    if (!m_has) begin
                        m_word = in_addr[31:2];
                        m_mask = '0;
                        for (int k = 0; k < 4; k++) m_bytes[k] = 8'h00;
                        m_has = 1;
                    end
                    for (int k = 0; k < nb; k++) begin
                        lane = lo + k;
                        m_bytes[lane] = in_data[8*k +: 8];
                        m_mask[lane]  = 1'b1;
                    end
                    m_idle = 0;
                end else if (was_has && m_idle < IDLE) begin
                    m_idle++;
                end
                if (m_has && (m_mask == 4'hF || flush || waiting ||
                    (IDLE > 0 && was_has && !aligned && idle_before == IDLE - 1))) begin
                    m_drain = 1;
                    m_idle  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input bit fl, output int waits);
        bit rdy;
        rdy      = 0;
        waits    = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_size  = sz;
        in_data  = d;
        flush    = fl;
        for (int n = 0; n < 64; n++) begin
            rdy = model_ready(a, 1'b1);
            cycle();
            if (rdy) break;
            waits++;
        end
        if (!rdy) check("store_hold_timeout", 32'(waits), 32'd0);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic wait_write(output int used);
        int start;
        start = dut_wr_cnt;
        used  = 0;
        while (dut_wr_cnt == start && used < 100) begin
            cycle();
            used++;
        end
        if (dut_wr_cnt == start) check("write_timeout", 32'(used), 32'd0);
    endtask

    initial begin
        int w, c, w0, e0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_size   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_wr_cnt    = 0;
        dut_wr_cnt  = 0;
        dut_err_cnt = 0;
        model_clear();
        repeat (2) cycle();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_be", 32'(out_be), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Four bytes fill one word.
        store(32'h100, 2'd0, 32'hAA, 0, w);
        store(32'h101, 2'd0, 32'hBB, 0, w);
        store(32'h102, 2'd0, 32'hCC, 0, w);
        store(32'h103, 2'd0, 32'hDD, 0, w);
        wait_write(c);
        check("comb_latency", 32'(c), 32'd1);
        check("comb_addr", last_addr, 32'h100);
        check("comb_data", last_data, 32'hDDCCBBAA);
        check("comb_be", 32'(last_be), 32'hF);

        // Half, then a byte to another word, then idle timeout.
        store(32'h202, 2'd1, 32'h1234, 0, w);
        store(32'h300, 2'd0, 32'h55, 0, w);
        check("hold_waits", 32'(w), 32'd2);
        check("half_addr", last_addr, 32'h200);
        check("half_data", last_data, 32'h12340000);
        check("half_be", 32'(last_be), 32'hC);
        wait_write(c);
        check("idle_cycles", 32'(c), 32'(IDLE + 1));
        check("idle_addr", last_addr, 32'h300);
        check("idle_data", last_data, 32'h55);
        check("idle_be", 32'(last_be), 32'h1);

        // Misaligned stores leave the buffer untouched.
        e0 = dut_err_cnt;
        w0 = dut_wr_cnt;
        store(32'h100, 2'd0, 32'h11, 0, w);
        store(32'h101, 2'd1, 32'hBEEF, 0, w);
        store(32'h102, 2'd2, 32'hCAFEF00D, 0, w);
        idle(1);
        check("mis_errs", 32'(dut_err_cnt - e0), 32'd2);
        check("mis_nowrite", 32'(dut_wr_cnt - w0), 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_write(c);
        check("mis_addr", last_addr, 32'h100);
        check("mis_data", last_data, 32'h11);
        check("mis_be", 32'(last_be), 32'h1);

        // Backpressure on a full word.
        out_ready = 1'b0;
        w0 = dut_wr_cnt;
        store(32'h40, 2'd2, 32'hDEADBEEF, 0, w);
        repeat (5) begin
            cycle();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'hDEADBEEF);
        end
        out_ready = 1'b1;
        wait_write(c);
        check("bp_release", 32'(c), 32'd1);
        check("bp_addr", last_addr, 32'h40);
        idle(2);
        check("bp_once", 32'(dut_wr_cnt - w0), 32'd1);

        // Flush together with a byte merges before draining.
        store(32'h80, 2'd0, 32'h11, 0, w);
        store(32'h81, 2'd0, 32'h77, 1, w);
        wait_write(c);
        check("fl_addr", last_addr, 32'h80);
        check("fl_data", last_data, 32'h7711);
        check("fl_be", 32'(last_be), 32'h3);

        // Reset while a write is pending.
        out_ready = 1'b0;
        w0 = dut_wr_cnt;
        store(32'h44, 2'd2, 32'h12345678, 0, w);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rd_out_valid", 32'(out_valid), 32'd0);
        check("rd_out_be", 32'(out_be), 32'd0);
        check("rd_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(3);
        check("rd_nowrite", 32'(dut_wr_cnt - w0), 32'd0);

        // Random traffic over a few neighbouring words.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 1);
            in_addr   = 32'h1000 + (32'($urandom_range(0, 2)) << 2) + 32'($urandom_range(0, 3));
            in_size   = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle(20);
        check("wr_count", 32'(dut_wr_cnt), 32'(m_wr_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
